mesi_bus_arbiter: RTL and testbench

MESI_BUS_ARBITER -- requirements
Module: mesi_bus_arbiter

---
 rtl/mesi_types.sv | 35 +++
 rtl/mesi_rr_picker.sv | 33 +++
 rtl/mesi_bus_arbiter.sv | 251 +++++++++++++++++++++++++
 tb/tb_mesi_bus_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mesi_types.sv
// ---------------------------------------------------------------------------
// mesi_types
// Shared types for the MESI snooping bus.
//   bus_request : command a cache puts on (or receives from) the bus
//   cache_state : per-line MESI state held by each cache_mem
//   is_bus_req  : true only for the three real bus commands
// ---------------------------------------------------------------------------
package mesi_types;

    localparam int BUS_REQ_W = 2;

    typedef enum logic [BUS_REQ_W-1:0] {
        No_OP   = 2'd0,
        BusRd   = 2'd1,
        BusRdX  = 2'd2,
        BusUpgr = 2'd3
    } bus_request;

    typedef enum logic [1:0] {
        Invalid   = 2'd0,
        Shared    = 2'd1,
        Exclusive = 2'd2,
        Modified  = 2'd3
    } cache_state;

    // Anything that is not a recognised command (including X/Z from an
    // unconnected core) falls into the default arm and counts as no request.
    function automatic logic is_bus_req(input logic [BUS_REQ_W-1:0] cmd);
        case (cmd)
            BusRd, BusRdX, BusUpgr: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mesi_rr_picker.sv
// ---------------------------------------------------------------------------
// mesi_rr_picker
// Combinational one-hot pick from a request vector, searching upward from a
// starting core and wrapping around. With ptr tied to zero it degenerates
// into fixed priority (lowest index wins).
//   req_vec : one bit per core, 1 = core is requesting the bus
//   ptr     : core index where the search starts
//   pick    : one-hot winner, all zero when nobody requests
// ---------------------------------------------------------------------------
module mesi_rr_picker #(
    parameter int N_CORES = 2,
    parameter int PTR_W   = 1
) (
    input  logic [N_CORES-1:0] req_vec,
    input  logic [PTR_W-1:0]   ptr,
    output logic [N_CORES-1:0] pick
);

    // Walk the cores starting at ptr; the first requester found wins.
    // The modulo keeps out-of-range pointer values inside the core range.
    always_comb begin
        logic found;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N_CORES; i++) begin
            if (!found && req_vec[(int'(ptr) + i) % N_CORES]) begin
                pick[(int'(ptr) + i) % N_CORES] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mesi_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mesi_bus_arbiter
// Serialises bus transactions from N_CORES MESI caches: picks one requester,
// broadcasts its command for snooping, performs an optional writeback of a
// dirty copy, a memory read for BusRd/BusRdX, and pulses done to the owner.
//
// Parameters: N_CORES (2..4), ADDR_W, MEM_LAT (1..15 memory cycles)
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   req_cmd         per-core bus_request, packed core0 in the low bits
//   req_addr        per-core address, packed core0 in the low bits
//   snoop_hit       per-core: holds the broadcast line (S/E/M)
//   snoop_dirty     per-core: holds the broadcast line in M
//   bus_cmd/addr    broadcast to every cache, non-zero only in BCAST
//   grant           one-hot transaction owner, zero in IDLE
//   done            one-cycle completion pulse to the owner
//   exclusive       with done: 1 = no other core held the line
//   mem_rd          high during each memory-read cycle
//   mem_wr          one-cycle writeback strobe
//   mem_addr        latched transaction address
//
// Build option: define MESI_BUS_RR_EN for round-robin arbitration; otherwise
// fixed priority with the lowest core index winning and no pointer register.
// ---------------------------------------------------------------------------
module mesi_bus_arbiter
    import mesi_types::*;
#(
    parameter int N_CORES = 2,
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_CORES*BUS_REQ_W-1:0]  req_cmd,
    input  logic [N_CORES*ADDR_W-1:0]     req_addr,
    input  logic [N_CORES-1:0]            snoop_hit,
    input  logic [N_CORES-1:0]            snoop_dirty,
    output logic [BUS_REQ_W-1:0]          bus_cmd,
    output logic [ADDR_W-1:0]             bus_addr,
    output logic [N_CORES-1:0]            grant,
    output logic [N_CORES-1:0]            done,
    output logic [N_CORES-1:0]            exclusive,
    output logic                          mem_rd,
    output logic                          mem_wr,
    output logic [ADDR_W-1:0]             mem_addr
);

    localparam int PTR_W = $clog2(N_CORES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BCAST,
        S_FLUSH,
        S_MEM,
        S_DONE
    } arb_state_e;

    arb_state_e               state_q, state_d;
    logic [BUS_REQ_W-1:0]     cmd_q, cmd_d;
    logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
    logic [N_CORES-1:0]       grant_q, grant_d;
    logic [N_CORES-1:0]       done_q, done_d;
    logic [N_CORES-1:0]       excl_q, excl_d;
    logic                     mem_rd_q, mem_rd_d;
    logic                     mem_wr_q, mem_wr_d;
    logic [BUS_REQ_W-1:0]     bus_cmd_q, bus_cmd_d;
    logic [ADDR_W-1:0]        bus_addr_q, bus_addr_d;
    logic                     shared_q, shared_d;
    logic                     dirty_q, dirty_d;
    logic [3:0]               cnt_q, cnt_d;

    logic [N_CORES-1:0]       req_vec;
    logic [N_CORES-1:0]       pick;
    logic [PTR_W-1:0]         pick_ptr;
    logic [BUS_REQ_W-1:0]     sel_cmd;
    logic [ADDR_W-1:0]        sel_addr;

`ifdef MESI_BUS_RR_EN
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic [PTR_W-1:0]         owner_idx;
    assign pick_ptr = ptr_q;
`else
    assign pick_ptr = '0;
`endif

    // Decode each core's command into a plain request bit and select the
    // winner's command and address for latching.
    always_comb begin
        req_vec  = '0;
        sel_cmd  = No_OP;
        sel_addr = '0;
        for (int i = 0; i < N_CORES; i++) begin
            req_vec[i] = is_bus_req(req_cmd[i*BUS_REQ_W +: BUS_REQ_W]);
            if (pick[i]) begin
                sel_cmd  = req_cmd[i*BUS_REQ_W +: BUS_REQ_W];
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    mesi_rr_picker #(
        .N_CORES (N_CORES),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req_vec (req_vec),
        .ptr     (pick_ptr),
        .pick    (pick)
    );

`ifdef MESI_BUS_RR_EN
    // Index of the current owner, used to move the round-robin pointer on.
    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (grant_q[i]) owner_idx = PTR_W'(i);
        end
    end
`endif

    // Next-state and next-output logic. Outputs are computed for the state
    // being entered so that every output comes straight from a flop.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        mem_addr_d = mem_addr_q;
        grant_d    = grant_q;
        shared_d   = shared_q;
        dirty_d    = dirty_q;
        cnt_d      = cnt_q;
        done_d     = '0;
        excl_d     = '0;
        mem_rd_d   = 1'b0;
        mem_wr_d   = 1'b0;
        bus_cmd_d  = No_OP;
        bus_addr_d = '0;
`ifdef MESI_BUS_RR_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req_vec) begin
                    state_d    = S_BCAST;
                    grant_d    = pick;
                    cmd_d      = sel_cmd;
                    mem_addr_d = sel_addr;
                    bus_cmd_d  = sel_cmd;
                    bus_addr_d = sel_addr;
                end
            end
            S_BCAST: begin
                // The owner's own snoop response must not count as sharing.
                shared_d = |(snoop_hit & ~grant_q);
                dirty_d  = |(snoop_dirty & ~grant_q);
                if (dirty_d) begin
                    state_d  = S_FLUSH;
                    mem_wr_d = 1'b1;
                end else if (cmd_q != BusUpgr) begin
                    state_d  = S_MEM;
                    cnt_d    = 4'(MEM_LAT - 1);
                    mem_rd_d = 1'b1;
                end else begin
                    state_d = S_DONE;
                    done_d  = grant_q;
                    excl_d  = grant_q;
                end
            end
            S_FLUSH: begin
                if (cmd_q != BusUpgr) begin
                    state_d  = S_MEM;
                    cnt_d    = 4'(MEM_LAT - 1);
                    mem_rd_d = 1'b1;
                end else begin
                    state_d = S_DONE;
                    done_d  = grant_q;
                    excl_d  = grant_q;
                end
            end
            S_MEM: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    done_d  = grant_q;
                    excl_d  = (cmd_q == BusRd && shared_q) ? '0 : grant_q;
                end else begin
                    cnt_d    = cnt_q - 4'd1;
                    mem_rd_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = '0;
`ifdef MESI_BUS_RR_EN
                ptr_d = (owner_idx == PTR_W'(N_CORES - 1)) ? '0 : owner_idx + 1'b1;
`endif
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Single state register for the FSM and all of its registered outputs.
    // Reset drops any transaction in flight without a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cmd_q      <= No_OP;
            mem_addr_q <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            excl_q     <= '0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            bus_cmd_q  <= No_OP;
            bus_addr_q <= '0;
            shared_q   <= 1'b0;
            dirty_q    <= 1'b0;
            cnt_q      <= 4'd0;
`ifdef MESI_BUS_RR_EN
            ptr_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            mem_addr_q <= mem_addr_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            excl_q     <= excl_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            bus_cmd_q  <= bus_cmd_d;
            bus_addr_q <= bus_addr_d;
            shared_q   <= shared_d;
            dirty_q    <= dirty_d;
            cnt_q      <= cnt_d;
`ifdef MESI_BUS_RR_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign bus_cmd   = bus_cmd_q;
    assign bus_addr  = bus_addr_q;
    assign grant     = grant_q;
    assign done      = done_q;
    assign exclusive = excl_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mesi_bus_arbiter
// Scoreboard bench for mesi_bus_arbiter with two cores. Each transaction's
// expected owner, broadcast, exclusive result, memory activity and latency
// are queued when the request is driven and checked by a monitor as the
// broadcast and done pulse appear. Follows MESI_BUS_RR_EN for arbitration.
// ---------------------------------------------------------------------------
module tb_mesi_bus_arbiter;
    import mesi_types::*;

    localparam int N_CORES = 2;
    localparam int ADDR_W  = 8;
    localparam int MEM_LAT = 2;

    typedef struct {
        logic [1:0] gnt;
        logic [1:0] cmd;
        logic [7:0] addr;
        logic [1:0] excl;
        int         rd;
        int         wr;
        int         lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_cmd;
    logic [15:0] req_addr;
    logic [1:0]  snoop_hit;
    logic [1:0]  snoop_dirty;
    logic [1:0]  bus_cmd;
    logic [7:0]  bus_addr;
    logic [1:0]  grant;
    logic [1:0]  done;
    logic [1:0]  exclusive;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_addr;

    int assertions = 0;
    int failures   = 0;
    int done_count = 0;
    exp_t sb[$];

    // Monitor bookkeeping
    bit in_txn    = 1'b0;
    int cyc       = 0;
    int bcast_cyc = 0;
    int bcast_cnt = 0;
    int rd_cnt    = 0;
    int wr_cnt    = 0;
    int stray     = 0;

    mesi_bus_arbiter #(
        .N_CORES (N_CORES),
        .ADDR_W  (ADDR_W),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_cmd     (req_cmd),
        .req_addr    (req_addr),
        .snoop_hit   (snoop_hit),
        .snoop_dirty (snoop_dirty),
        .bus_cmd     (bus_cmd),
        .bus_addr    (bus_addr),
        .grant       (grant),
        .done        (done),
        .exclusive   (exclusive),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertions++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model of one transaction, queued before the request is driven.
    task automatic pushExpected(input int core, input logic [1:0] cmd, input logic [7:0] addr,
                                input logic [1:0] hit, input logic [1:0] dirty);
        exp_t e;
        logic [1:0] mask;
        logic shared_o, dirty_o;
        mask     = 2'b01 << core;
        shared_o = |(hit & ~mask);
        dirty_o  = |(dirty & ~mask);
        e.gnt  = mask;
        e.cmd  = cmd;
        e.addr = addr;
        e.excl = (cmd == BusRd && shared_o) ? 2'b00 : mask;
        e.rd   = (cmd == BusUpgr) ? 0 : MEM_LAT;
        e.wr   = dirty_o ? 1 : 0;
        e.lat  = 2 + e.rd + e.wr;
        sb.push_back(e);
    endtask

    task automatic waitDones(input int target, input int budget);
        int n = 0;
        while (done_count < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("done_count", done_count, target);
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Drive a single request, hold it until its done pulse, then release it.
    task automatic applyStimulus(input int core, input logic [1:0] cmd, input logic [7:0] addr,
                                 input logic [1:0] hit, input logic [1:0] dirty);
        pushExpected(core, cmd, addr, hit, dirty);
        snoop_hit   = hit;
        snoop_dirty = dirty;
        req_cmd[core*2 +: 2]  = cmd;
        req_addr[core*8 +: 8] = addr;
        waitDones(done_count + 1, 40);
        req_cmd     = '0;
        req_addr    = '0;
        snoop_hit   = '0;
        snoop_dirty = '0;
        @(negedge clk); #1;
        checkOutput("grant_idle", grant, 2'b00);
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            in_txn = 1'b0;
        end else begin
            if (bus_cmd != No_OP) begin
                if (!in_txn) begin
                    in_txn    = 1'b1;
                    bcast_cyc = cyc;
                    bcast_cnt = 0;
                    rd_cnt    = 0;
                    wr_cnt    = 0;
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_bcast", bus_cmd, No_OP);
                    end else begin
                        checkOutput("bcast_cmd", bus_cmd, sb[0].cmd);
                        checkOutput("bcast_addr", bus_addr, sb[0].addr);
                        checkOutput("bcast_grant", grant, sb[0].gnt);
                    end
                end
                bcast_cnt++;
            end else if (bus_addr != 8'h00) begin
                stray++;
            end
            if (in_txn) begin
                if (mem_rd) rd_cnt++;
                if (mem_wr) begin
                    wr_cnt++;
                    if (sb.size() != 0) checkOutput("flush_addr", mem_addr, sb[0].addr);
                end
            end else if (mem_rd || mem_wr) begin
                stray++;
            end
            if (done != 2'b00) begin
                if (!in_txn || sb.size() == 0) begin
                    checkOutput("unexpected_done", done, 2'b00);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("done_owner", done, e.gnt);
                    checkOutput("exclusive", exclusive, e.excl);
                    checkOutput("mem_rd_cycles", rd_cnt, e.rd);
                    checkOutput("mem_wr_cycles", wr_cnt, e.wr);
                    checkOutput("latency", cyc - bcast_cyc + 1, e.lat);
                    checkOutput("bcast_cycles", bcast_cnt, 1);
                    checkOutput("bus_idle_clean", stray, 0);
                    in_txn = 1'b0;
                    done_count++;
                end
            end
            cyc++;
        end
    end

    initial begin
        int n;
        rst         = 1'b0;
        req_cmd     = '0;
        req_addr    = '0;
        snoop_hit   = '0;
        snoop_dirty = '0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_grant", grant, 2'b00);
        checkOutput("rst_done", done, 2'b00);
        checkOutput("rst_excl", exclusive, 2'b00);
        checkOutput("rst_mem_rd", mem_rd, 1'b0);
        checkOutput("rst_mem_wr", mem_wr, 1'b0);
        checkOutput("rst_bus_cmd", bus_cmd, No_OP);
        checkOutput("rst_bus_addr", bus_addr, 8'h00);
        checkOutput("rst_mem_addr", mem_addr, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] directed single-core transactions");
        applyStimulus(0, BusRd,   8'h10, 2'b00, 2'b00);
        applyStimulus(1, BusRd,   8'h20, 2'b01, 2'b01);
        applyStimulus(0, BusUpgr, 8'h30, 2'b10, 2'b00);
        applyStimulus(0, BusRd,   8'h34, 2'b01, 2'b01);
        applyStimulus(1, BusRdX,  8'h44, 2'b01, 2'b00);
        applyStimulus(0, BusUpgr, 8'h58, 2'b10, 2'b10);
        applyStimulus(1, BusRd,   8'hFF, 2'b01, 2'b00);

        $display("[TB] request arriving mid-transaction waits for IDLE");
        pushExpected(0, BusRd, 8'h60, 2'b00, 2'b00);
        pushExpected(1, BusUpgr, 8'h70, 2'b00, 2'b00);
        req_cmd[1:0]  = BusRd;
        req_addr[7:0] = 8'h60;
        n = 0;
        while (bus_cmd == No_OP && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        req_cmd[3:2]   = BusUpgr;
        req_addr[15:8] = 8'h70;
        waitDones(done_count + 1, 40);
        req_cmd[1:0]  = No_OP;
        req_addr[7:0] = 8'h00;
        waitDones(done_count + 1, 40);
        req_cmd  = '0;
        req_addr = '0;
        @(negedge clk); #1;
        checkOutput("grant_idle", grant, 2'b00);

        $display("[TB] reset during MEM");
        pushExpected(0, BusRd, 8'h80, 2'b00, 2'b00);
        req_cmd[1:0]  = BusRd;
        req_addr[7:0] = 8'h80;
        n = 0;
        while (!mem_rd && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("mem_rd_seen", mem_rd, 1'b1);
        rst = 1'b0;
        #1;
        sb.delete();
        checkOutput("arst_grant", grant, 2'b00);
        checkOutput("arst_mem_rd", mem_rd, 1'b0);
        checkOutput("arst_mem_addr", mem_addr, 8'h00);
        checkOutput("arst_bus_cmd", bus_cmd, No_OP);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            checkOutput("done_in_reset", done, 2'b00);
        end
        pushExpected(0, BusRd, 8'h80, 2'b00, 2'b00);
        rst = 1'b1;
        waitDones(done_count + 1, 40);
        req_cmd  = '0;
        req_addr = '0;
        @(negedge clk); #1;
        checkOutput("grant_idle", grant, 2'b00);

        $display("[TB] both cores holding BusRdX");
        resetDut();
        for (int i = 0; i < 4; i++) begin
`ifdef MESI_BUS_RR_EN
            pushExpected(i % 2, BusRdX, (i % 2 == 0) ? 8'h40 : 8'h50, 2'b00, 2'b00);
`else
            pushExpected(0, BusRdX, 8'h40, 2'b00, 2'b00);
`endif
        end
        req_cmd  = {BusRdX, BusRdX};
        req_addr = {8'h50, 8'h40};
        waitDones(done_count + 4, 100);
        req_cmd  = '0;
        req_addr = '0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("grant_idle", grant, 2'b00);
        checkOutput("sb_drained", sb.size(), 0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
